muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand and result width; legal values are even, 8..64.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled on rising edges.
REQ-005 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 SHALL have ports a and b, inputs, WIDTH bits each: multiplicand/multiplier, or dividend/divisor.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have ports hi and lo, outputs, WIDTH bits each: product upper/lower half, or remainder/quotient.
REQ-010 SHALL have port div_by_zero, output, 1 bit: the last completed division had b == 0.

Function
REQ-011 SHALL implement a state machine with states IDLE, CALC and SIGN.
REQ-012 SHALL, in IDLE, accept start=1 on edge E0:
  - latch op, |a|, |b| and the result signs (magnitudes for signed ops; raw values for unsigned ops);
  - go to CALC with the iteration counter set to WIDTH-1.
REQ-013 SHALL perform one step per cycle in CALC:
  - multiply: shift-add;
  - divide: restoring divide;
  - decrement the counter; go to SIGN after the step with counter == 0, i.e. WIDTH CALC cycles.
REQ-014 SHALL, in SIGN, two's-complement negate the result per the latched signs, then go to IDLE.
REQ-015 SHALL update hi, lo and div_by_zero, and pulse done for exactly one cycle, at edge E0+WIDTH+1.
REQ-016 SHALL drive busy high from edge E0 until edge E0+WIDTH+1, and low during the done cycle.
REQ-017 SHALL ignore start while busy=1, with no effect on the operation in progress.
REQ-018 SHALL accept start asserted during the done cycle as a new operation (back-to-back, zero bubble).
REQ-019 SHALL hold hi, lo and div_by_zero between completions.
REQ-020 SHALL produce a signed product exact in 2*WIDTH bits, with hi carrying the upper half including the sign.
REQ-021 SHALL truncate the signed quotient toward zero; the remainder takes the sign of the dividend.
REQ-022 SHALL, on divide by zero:
  - set lo = all ones and hi = a (unmodified dividend);
  - assert div_by_zero;
  - keep the normal latency.
REQ-023 SHALL, for signed MIN / -1, give lo = MIN and hi = 0, with div_by_zero = 0.
REQ-024 SHALL clear div_by_zero on every completed multiply or non-zero-divisor divide.

Reset
REQ-025 SHALL, while reset_n = 0, asynchronously force:
  - state = IDLE, counter = 0;
  - busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0.
REQ-026 SHALL discard an operation in progress if reset occurs mid-operation; no done pulse follows reset.
REQ-027 SHALL accept start on the first rising edge after reset_n rises.

Configuration
REQ-028 SHALL, with macro MULDIV_DIV_EN defined, implement DIVU and DIV as specified above.
REQ-029 SHALL, without MULDIV_DIV_EN, complete a division op as follows:
  - IDLE -> SIGN -> IDLE, with done at edge E0+2;
  - hi = lo = 0 and div_by_zero = 0;
  - no divider logic synthesised.

Structure
REQ-030 SHALL take the op encoding enum, the state enum and the WIDTH legality checks from shared package muldiv_pkg.
REQ-031 SHALL contain one sub-module, muldiv_negate: a combinational WIDTH-bit two's-complement conditional negate, instanced for operand conditioning and result fix-up.

Verification
REQ-032 SHALL verify, with WIDTH=16: MULTU a=7, b=5 -> hi=0x0000, lo=0x0023, done at edge E0+17, busy high for 17 cycles.
REQ-033 SHALL verify: MULT a=0xFFFD (-3), b=5 -> hi=0xFFFF, lo=0xFFF1.
REQ-034 SHALL verify: DIV a=0xFFF9 (-7), b=2 -> lo=0xFFFD, hi=0xFFFF, div_by_zero=0; and DIV a=0x8000, b=0xFFFF -> lo=0x8000, hi=0.
REQ-035 SHALL verify: DIVU a=100, b=0 -> lo=0xFFFF, hi=0x0064, div_by_zero=1; a following MULTU clears div_by_zero.
REQ-036 SHALL verify: reset_n pulsed low at E0+5 -> busy=0, hi=lo=0, no done; and start held through the done cycle -> second result at E0+34 with no gap.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation/state encodings and WIDTH legality check shared by the
// muldiv_unit sources.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10
    } state_e;

    localparam int MULDIV_MIN_WIDTH = 32'sd8;
    localparam int MULDIV_MAX_WIDTH = 32'sd64;

    function automatic bit width_legal(input int w);
        return (w >= MULDIV_MIN_WIDTH) && (w <= MULDIV_MAX_WIDTH) && ((w % 32'sd2) == 32'sd0);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: combinational conditional two's-complement negate.
module muldiv_negate
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] result_o
);

    // Pass through or negate.
    always_comb begin
        if (neg_i) begin
            result_o = ~value_i + WIDTH'(1);
        end else begin
            result_o = value_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider, one bit per cycle.
// The divider exists only when MULDIV_DIV_EN is defined; otherwise divides complete as zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("muldiv_unit: WIDTH must be even and within 8..64");
    end

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d, negr_q, negr_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic             busy_q, busy_d, done_q, done_d, divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic             ld_div_s, ld_sgn_s, b_zero_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    state_e           ld_state_s;
    logic [CW-1:0]    ld_cnt_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] div_hi_s, div_lo_s;
    logic             hi_neg_en_s;
    logic [WIDTH-1:0] lo_fix_s, hi_fix_s, res_hi_s, res_lo_s;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
    logic [WIDTH:0] div_shift_s, div_diff_s;

    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, mcand_q};
    assign div_hi_s    = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
    assign div_lo_s    = {acc_lo_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
`else
    localparam bit DIV_EN = 1'b0;
    assign div_hi_s = {WIDTH{1'b0}};
    assign div_lo_s = {WIDTH{1'b0}};
`endif

    assign ld_div_s = op_is_div(op_e'(op));
    assign ld_sgn_s = op_is_signed(op_e'(op));
    assign b_zero_s = (b == {WIDTH{1'b0}});

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
        .value_i (a),
        .neg_i   (ld_sgn_s & a[WIDTH-1]),
        .result_o(a_mag_s)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
        .value_i (b),
        .neg_i   (ld_sgn_s & b[WIDTH-1]),
        .result_o(b_mag_s)
    );

    // Disabled divides take two SIGN cycles so they still complete at E0+2.
    assign ld_state_s = (ld_div_s && !DIV_EN) ? ST_SIGN : ST_CALC;
    assign ld_cnt_s   = (ld_div_s && !DIV_EN) ? CW'(1) : CW'(WIDTH - 1);

    assign mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});

    assign hi_neg_en_s = op_is_div(op_q) ? negr_q : negq_q;

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_lo (
        .value_i (acc_lo_q),
        .neg_i   (negq_q),
        .result_o(lo_fix_s)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_hi (
        .value_i (acc_hi_q),
        .neg_i   (hi_neg_en_s),
        .result_o(hi_fix_s)
    );

    // Final result select; a negated double-width product borrows from hi unless lo is zero.
    always_comb begin
        if (op_is_div(op_q) && !DIV_EN) begin
            res_hi_s = {WIDTH{1'b0}};
            res_lo_s = {WIDTH{1'b0}};
        end else if (!op_is_div(op_q) && negq_q && (acc_lo_q != {WIDTH{1'b0}})) begin
            res_hi_s = ~acc_hi_q;
            res_lo_s = lo_fix_s;
        end else begin
            res_hi_s = hi_fix_s;
            res_lo_s = lo_fix_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dbz_d    = dbz_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        divz_d   = divz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ld_state_s;
                    cnt_d    = ld_cnt_s;
                    op_d     = op_e'(op);
                    negq_d   = ld_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(ld_div_s & b_zero_s);
                    negr_d   = ld_sgn_s & ld_div_s & a[WIDTH-1];
                    dbz_d    = DIV_EN & ld_div_s & b_zero_s;
                    mcand_d  = ld_div_s ? b_mag_s : a_mag_s;
                    acc_hi_d = {WIDTH{1'b0}};
                    acc_lo_d = ld_div_s ? a_mag_s : b_mag_s;
                    busy_d   = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_CALC: begin
                busy_d = 1'b1;
                if (op_is_div(op_q)) begin
                    acc_hi_d = div_hi_s;
                    acc_lo_d = div_lo_s;
                end else begin
                    acc_hi_d = mul_sum_s[WIDTH:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_SIGN;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = ST_CALC;
                end
            end
            ST_SIGN: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = ST_SIGN;
                    busy_d  = 1'b1;
                end else begin
                    done_d = 1'b1;
                    hi_d   = res_hi_s;
                    lo_d   = res_lo_s;
                    divz_d = dbz_q;
                    if (start) begin
                        state_d  = ld_state_s;
                        cnt_d    = ld_cnt_s;
                        op_d     = op_e'(op);
                        negq_d   = ld_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(ld_div_s & b_zero_s);
                        negr_d   = ld_sgn_s & ld_div_s & a[WIDTH-1];
                        dbz_d    = DIV_EN & ld_div_s & b_zero_s;
                        mcand_d  = ld_div_s ? b_mag_s : a_mag_s;
                        acc_hi_d = {WIDTH{1'b0}};
                        acc_lo_d = ld_div_s ? a_mag_s : b_mag_s;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULTU;
            cnt_q    <= {CW{1'b0}};
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dbz_q    <= 1'b0;
            mcand_q  <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dbz_q    <= dbz_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            divz_q   <= divz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (WIDTH=16) against an
// arithmetic reference model; follows MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;

    localparam int W = 16;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result by plain arithmetic, latency in edges from E0 to done.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic ez, output int lat);
        longint p;
        int     q;
        int     r;
        eh = 16'h0000;
        el = 16'h0000;
        ez = 1'b0;
        lat = W + 1;
        if (o == 2'd0) begin
            p = longint'(x) * longint'(y);
            eh = p[31:16];
            el = p[15:0];
        end else if (o == 2'd1) begin
            p = longint'($signed(x)) * longint'($signed(y));
            eh = p[31:16];
            el = p[15:0];
        end else if (!DIV_EN) begin
            lat = 2;
        end else if (y == 16'h0000) begin
            eh = x;
            el = 16'hFFFF;
            ez = 1'b1;
        end else if (o == 2'd2) begin
            el = x / y;
            eh = x % y;
        end else begin
            q = int'($signed(x)) / int'($signed(y));
            r = int'($signed(x)) % int'($signed(y));
            el = q[15:0];
            eh = r[15:0];
        end
    endfunction

    function automatic logic [W-1:0] pick_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'h0000;
            1: v = 16'h0001;
            2: v = 16'hFFFF;
            3: v = 16'h8000;
            4: v = 16'h7FFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // One operation: start at E0, follow busy, check latency, result, pulse width and hold.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit poke);
        logic [W-1:0] eh, el;
        logic         ez;
        int           elat, lat, nbusy;
        model(o, x, y, eh, el, ez, elat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        nbusy = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            if (poke && lat == 5) begin
                start = 1'b1; op = ~o; a = ~x; b = y ^ 16'h00F0;
            end
            if (lat == 6) start = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(elat));
        check({tag, " busy in done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(ez));
        @(posedge clock); #1;
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " hi hold"}, 64'(hi), 64'(eh));
    endtask

    initial begin
        logic [W-1:0] eh1, el1, eh2, el2;
        logic         ez1, ez2;
        int           l1, l2, lat;
        bit           seen;

        reset_n = 1'b0; start = 1'b0; op = 2'd0; a = 16'h0000; b = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("multu 7x5", 2'd0, 16'h0007, 16'h0005, 1'b0);
        run_op("mult -3x5", 2'd1, 16'hFFFD, 16'h0005, 1'b1);
        run_op("div -7/2", 2'd3, 16'hFFF9, 16'h0002, 1'b0);
        run_op("div min/-1", 2'd3, 16'h8000, 16'hFFFF, 1'b0);
        run_op("divu 100/0", 2'd2, 16'h0064, 16'h0000, 1'b0);
        run_op("multu clr", 2'd0, 16'h1234, 16'h0010, 1'b0);
        run_op("div -9/0", 2'd3, 16'hFFF7, 16'h0000, 1'b0);
        run_op("mult minxmin", 2'd1, 16'h8000, 16'h8000, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), pick_val(), pick_val(), (i % 3) == 0);
        end

        // Reset mid-operation: outputs clear at once and no done follows.
        op = 2'd0; a = 16'h0101; b = 16'h0033; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst no done", 64'(seen), 64'd0);

        // Back-to-back: start held through the done cycle, operands changed while busy.
        model(2'd0, 16'h1234, 16'h0042, eh1, el1, ez1, l1);
        model(2'd1, 16'hFF00, 16'h0003, eh2, el2, ez2, l2);
        op = 2'd0; a = 16'h1234; b = 16'h0042; start = 1'b1;
        @(posedge clock); #1;
        op = 2'd1; a = 16'hFF00; b = 16'h0003;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b first latency", 64'(lat), 64'(l1));
        check("b2b first hi", 64'(hi), 64'(eh1));
        check("b2b first lo", 64'(lo), 64'(el1));
        check("b2b second running", 64'(busy), 64'd1);
        start = 1'b0;
        @(posedge clock); #1;
        lat++;
        check("b2b done pulse", 64'(done), 64'd0);
        while (done !== 1'b1 && lat < 80) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b second latency", 64'(lat), 64'(l1 + l2));
        check("b2b second hi", 64'(hi), 64'(eh2));
        check("b2b second lo", 64'(lo), 64'(el2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
